add_pipe: RTL
=============

Name: add_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor for the CPU datapath. It is the successor to the single-cycle combinational adder.
- Operand width is split into STAGES carry-segmented slices, one slice per pipeline register, to close timing at higher clock rates.
- Adds add/sub/add-with-carry/subtract-with-borrow modes, NZCV-style flags, and a valid/ready handshake with backpressure.
- Sits between the operand-select logic and the writeback mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages = carry segments; 1..WIDTH. Latency in cycles when not stalled.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands and op valid this cycle
- in_ready  output  1  block accepts an input this cycle
- op  input  2  00 add (a+b), 01 sub (a+~b+1), 10 adc (a+b+cin), 11 sbb (a+~b+cin)
- cin  input  1  carry-in, used only by adc/sbb
- data_in_1  input  WIDTH  operand a
- data_in_2  input  WIDTH  operand b
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts result
- data_out  output  WIDTH  result
- flag_c  output  1  carry out of MSB (for sub/sbb: 1 = no borrow)
- flag_v  output  1  signed overflow
- flag_z  output  1  data_out == 0
- flag_n  output  1  data_out[WIDTH-1]

Behaviour:
- Clocking and reset: single clock `clk`. Reset `rst` is synchronous and active-high; no asynchronous paths.
- Reset state: every stage valid bit = 0, out_valid = 0, data_out = 0, all flags = 0. in_ready = 1 in the cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded and the block returns to the reset state next cycle.
- Slicing: SEG = WIDTH/STAGES.
  - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of a and b_eff using the carry from stage k-1. Stage 0 uses carry_in.
  - b_eff = op[0] ? ~b : b.
  - carry_in = op[1] ? cin : op[0].
  - Not-yet-consumed operand slices travel with the transaction. Completed sum slices are carried forward.
- Latency: STAGES cycles from input handshake to out_valid when unstalled. Throughput is 1 result per cycle.
- Flags, computed from the final-stage carry chain:
  - flag_c = carry out of bit WIDTH-1.
  - flag_v = carry into MSB XOR carry out of MSB.
  - flag_z and flag_n are taken from the final data_out.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Pipeline advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
  - When adv = 0, all stage registers, data_out and flags hold. No bubble compression.
  - data_out and flags are stable while out_valid && !out_ready.
- Simultaneous events:
  - Output transfer plus input accept in the same cycle is legal; no dead cycle.
  - in_valid = 0 with adv = 1 inserts a bubble (stage valid = 0).
- Arithmetic: modulo 2^WIDTH. Unsigned and signed interpretations are both supported via the flags.
- STAGES = 1: a single registered full-width adder with latency 1.

Optional Feature:
- Macro: ADD_PIPE_SATURATE_EN.
- When defined:
  - Extra input port `sat` (1 bit) is sampled with the operands and travels with the transaction.
  - If sat = 1 and flag_v = 1, data_out clamps to the signed maximum (0x7FFFFFFF for WIDTH=32) when a[MSB] = 0, else to the signed minimum (0x80000000).
  - flag_v still reports 1. flag_z and flag_n reflect the clamped value. flag_c is unchanged.
- When undefined: no `sat` port; results always wrap.

Test Plan (WIDTH=32, STAGES=2):
- Reset: assert rst for 2 cycles mid-stream with 2 transactions in flight -> out_valid = 0, data_out = 0, flags = 0; neither transaction ever appears.
- Add: a = 0xFFFFFFFF, b = 0x00000001, op = 00 -> after 2 cycles data_out = 0, flag_c = 1, flag_z = 1, flag_v = 0, flag_n = 0.
- Sub overflow: a = 0x80000000, b = 0x00000001, op = 01 -> data_out = 0x7FFFFFFF, flag_v = 1, flag_c = 1, flag_n = 0.
- Carry across slices: op = 10, cin = 1, a = 0x0000FFFF, b = 0x00000000 -> data_out = 0x00010000, flag_c = 0.
- Backpressure: stream 4 back-to-back adds (i+1 for i = 0..3), hold out_ready = 0 for 3 cycles after the first out_valid -> in_ready = 0 during the stall, results hold, all 4 emerge in order, none lost or duplicated.
- Saturation (ADD_PIPE_SATURATE_EN): a = 0x7FFFFFFF, b = 1, op = 00, sat = 1 -> data_out = 0x7FFFFFFF, flag_v = 1. Same with sat = 0 -> data_out = 0x80000000, flag_n = 1.

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined, carry-segmented integer adder/subtractor with NZCV flags
// and a valid/ready handshake with backpressure.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready is combinational)
//   op, cin              00 add, 01 sub, 10 adc, 11 sbb; cin used by adc/sbb
//   data_in_1/_2         operands a / b
//   sat                  saturate on signed overflow (ADD_PIPE_SATURATE_EN only)
//   out_valid/out_ready  output handshake
//   data_out, flag_*     registered result and carry/overflow/zero/negative
//
// Optional feature: define ADD_PIPE_SATURATE_EN to add the `sat` input.
// Saturation clamps signed overflow to the signed max/min value.
//
// Operands are split into STAGES slices of SEG bits. Stage k adds slice k
// using the carry out of stage k-1. The last stage register is the output register.
module add_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] data_in_1,
    input  logic [WIDTH-1:0] data_in_2,
`ifdef ADD_PIPE_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Per-stage transaction state: operands (b already inverted for sub),
    // partial sum, carry out of the slice just added, saturate request.
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             sat_q [STAGES];
    logic             sat_d [STAGES];
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic             adv_c;
    logic             sat_in;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] res;
    logic             ovf;

`ifdef ADD_PIPE_SATURATE_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // One carry-segment add: SEG-bit slice plus carry-in, carry out in the MSB.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
        return {1'b0, x} + {1'b0, y} + (SEG+1)'(ci);
    endfunction

    // Next-state for every stage; everything holds while the output is stalled.
    always_comb begin
        vld_d   = vld_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        sat_d   = sat_q;
        v_d     = v_q;
        z_d     = z_q;
        seg_sum = '0;
        src_s   = '0;
        res     = '0;
        ovf     = 1'b0;
        adv_c   = !vld_q[LAST] || out_ready;

        if (adv_c) begin
            // Stage 0 consumes the raw inputs.
            vld_d[0] = in_valid;
            a_d[0]   = data_in_1;
            b_d[0]   = op[0] ? ~data_in_2 : data_in_2;
            sat_d[0] = sat_in;
            seg_sum  = seg_add(data_in_1[SEG-1:0], b_d[0][SEG-1:0],
                               op[1] ? cin : op[0]);
            src_s           = '0;
            src_s[SEG-1:0]  = seg_sum[SEG-1:0];
            s_d[0]   = src_s;
            c_d[0]   = seg_sum[SEG];

            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                sat_d[k] = sat_q[k-1];
                seg_sum  = seg_add(a_q[k-1][k*SEG +: SEG], b_q[k-1][k*SEG +: SEG],
                                   c_q[k-1]);
                src_s    = s_q[k-1];
                src_s[k*SEG +: SEG] = seg_sum[SEG-1:0];
                s_d[k]   = src_s;
                c_d[k]   = seg_sum[SEG];
            end

            // Carry into the MSB is recovered from the MSB sum bit.
            ovf = c_d[LAST] ^ (a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1]);
            res = s_d[LAST];
            if (sat_d[LAST] && ovf) begin
                res = a_d[LAST][WIDTH-1] ? SMIN : SMAX;
            end
            s_d[LAST] = res;
            v_d       = ovf;
            z_d       = (res == '0);
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sat_q[k] <= 1'b0;
            end
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            sat_q <= sat_d;
            v_q   <= v_d;
            z_q   <= z_d;
        end
    end

    assign in_ready  = adv_c;
    assign out_valid = vld_q[LAST];
    assign data_out  = s_q[LAST];
    assign flag_c    = c_q[LAST];
    assign flag_v    = v_q;
    assign flag_z    = z_q;
    assign flag_n    = s_q[LAST][WIDTH-1];

endmodule
